// File: rtl/pcie_cfg_mgmt_pkg.sv
// Shared definitions for the cfg_mgmt arbiter: FSM encoding, timeout defaults
// and the round-robin pointer helper.
package pcie_cfg_mgmt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  // Wide enough for any practical DATA_WIDTH; users slice the low bits.
  localparam logic [1023:0] TIMEOUT_RDATA = '1;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority encoder: grants the lowest requesting
// index at or after (last_grant+1) mod CHANNELS.
module rr_arbiter #(
  parameter  int CHANNELS = 2,
  localparam int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IDX_W-1:0]    last_grant,
  output logic [CHANNELS-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                grant_vld
);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = (int'(last_grant) + 1 + k) % CHANNELS;
      if (!grant_vld && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
        grant_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_cfg_mgmt_arb.sv
// Round-robin arbiter sharing one PCIe cfg_mgmt port among CHANNELS requesters.
// Define CFG_MGMT_ARB_TIMEOUT_EN to force completion (with error) after TIMEOUT_CYCLES.
module pcie_cfg_mgmt_arb
  import pcie_cfg_mgmt_pkg::*;
#(
  parameter int CHANNELS       = 2,
  parameter int ADDR_WIDTH     = 10,
  parameter int FUNC_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CHANNELS*ADDR_WIDTH-1:0]   s_cfg_mgmt_addr,
  input  logic [CHANNELS*FUNC_WIDTH-1:0]   s_cfg_mgmt_function_number,
  input  logic [CHANNELS-1:0]              s_cfg_mgmt_write,
  input  logic [CHANNELS*DATA_WIDTH-1:0]   s_cfg_mgmt_write_data,
  input  logic [CHANNELS*DATA_WIDTH/8-1:0] s_cfg_mgmt_byte_enable,
  input  logic [CHANNELS-1:0]              s_cfg_mgmt_read,
  output logic [DATA_WIDTH-1:0]            s_cfg_mgmt_read_data,
  output logic [CHANNELS-1:0]              s_cfg_mgmt_read_write_done,
  output logic [CHANNELS-1:0]              s_cfg_mgmt_error,
  output logic [ADDR_WIDTH-1:0]            m_cfg_mgmt_addr,
  output logic [FUNC_WIDTH-1:0]            m_cfg_mgmt_function_number,
  output logic                             m_cfg_mgmt_write,
  output logic [DATA_WIDTH-1:0]            m_cfg_mgmt_write_data,
  output logic [DATA_WIDTH/8-1:0]          m_cfg_mgmt_byte_enable,
  output logic                             m_cfg_mgmt_read,
  input  logic [DATA_WIDTH-1:0]            m_cfg_mgmt_read_data,
  input  logic                             m_cfg_mgmt_read_write_done,
  output logic                             busy
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BE_W  = DATA_WIDTH / 8;

  arb_state_e          state, state_nxt;
  logic [IDX_W-1:0]    rr_ptr, grant_q, arb_last, arb_idx;
  logic [CHANNELS-1:0] req_vec, arb_grant;
  logic                arb_vld;
  logic                load_req, core_done, time_out, complete;

  assign req_vec  = s_cfg_mgmt_write | s_cfg_mgmt_read;
  // rr_ptr is the next index to favour; the arbiter wants the one before it.
  assign arb_last = (rr_ptr == '0) ? IDX_W'(CHANNELS - 1) : rr_ptr - 1'b1;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_rr (
    .req        (req_vec),
    .last_grant (arb_last),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .grant_vld  (arb_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (arb_vld)  state_nxt = ST_ACCESS;
      ST_ACCESS: if (complete) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    load_req  = (state == ST_IDLE) && arb_vld;
    core_done = (state == ST_ACCESS) && m_cfg_mgmt_read_write_done;
    complete  = core_done || time_out;
  end

`ifdef CFG_MGMT_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  to_cnt <= '0;
    else if (load_req)           to_cnt <= '0;
    else if (state == ST_ACCESS) to_cnt <= to_cnt + 1'b1;
  end

  // Core done in the same cycle takes precedence over the forced completion.
  assign time_out = (state == ST_ACCESS) && !m_cfg_mgmt_read_write_done &&
                    (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign time_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr                     <= '0;
      grant_q                    <= '0;
      m_cfg_mgmt_addr            <= '0;
      m_cfg_mgmt_function_number <= '0;
      m_cfg_mgmt_write           <= 1'b0;
      m_cfg_mgmt_read            <= 1'b0;
      m_cfg_mgmt_write_data      <= '0;
      m_cfg_mgmt_byte_enable     <= '0;
      s_cfg_mgmt_read_data       <= '0;
      s_cfg_mgmt_read_write_done <= '0;
      s_cfg_mgmt_error           <= '0;
    end else begin
      s_cfg_mgmt_read_write_done <= '0;
      s_cfg_mgmt_error           <= '0;
      if (load_req) begin
        grant_q                    <= arb_idx;
        m_cfg_mgmt_addr            <= s_cfg_mgmt_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
        m_cfg_mgmt_function_number <= s_cfg_mgmt_function_number[arb_idx*FUNC_WIDTH +: FUNC_WIDTH];
        m_cfg_mgmt_write_data      <= s_cfg_mgmt_write_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
        m_cfg_mgmt_byte_enable     <= s_cfg_mgmt_byte_enable[arb_idx*BE_W +: BE_W];
        // Write wins when a channel raises both.
        m_cfg_mgmt_write           <= |(arb_grant & s_cfg_mgmt_write);
        m_cfg_mgmt_read            <= |(arb_grant & s_cfg_mgmt_read & ~s_cfg_mgmt_write);
      end
      if (complete) begin
        s_cfg_mgmt_read_data                <= time_out ? TIMEOUT_RDATA[DATA_WIDTH-1:0]
                                                        : m_cfg_mgmt_read_data;
        s_cfg_mgmt_read_write_done[grant_q] <= 1'b1;
        s_cfg_mgmt_error[grant_q]           <= time_out;
        m_cfg_mgmt_write                    <= 1'b0;
        m_cfg_mgmt_read                     <= 1'b0;
      end
      if (state == ST_DONE) rr_ptr <= IDX_W'(rr_next(32'(grant_q), CHANNELS));
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_pcie_cfg_mgmt_arb.sv
// Randomised bench for pcie_cfg_mgmt_arb: requesters and a core model drive the DUT,
// a transaction-level arbitration model predicts grants and completions.
module tb_pcie_cfg_mgmt_arb;

  localparam int CH = 3;
  localparam int AW = 10;
  localparam int FW = 8;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [CH*AW-1:0] s_addr = '0;
  logic [CH*FW-1:0] s_fn   = '0;
  logic [CH-1:0]    s_wr   = '0;
  logic [CH*DW-1:0] s_wd   = '0;
  logic [CH*BW-1:0] s_be   = '0;
  logic [CH-1:0]    s_rd   = '0;
  logic [DW-1:0]    s_rdata;
  logic [CH-1:0]    s_done, s_err;
  logic [AW-1:0]    m_addr;
  logic [FW-1:0]    m_fn;
  logic             m_write, m_read, busy;
  logic [DW-1:0]    m_wd;
  logic [BW-1:0]    m_be;
  logic [DW-1:0]    m_rdata = '0;
  logic             m_done  = 1'b0;

  always #5 clk = ~clk;

  pcie_cfg_mgmt_arb #(
    .CHANNELS(CH), .ADDR_WIDTH(AW), .FUNC_WIDTH(FW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .s_cfg_mgmt_addr            (s_addr),
    .s_cfg_mgmt_function_number (s_fn),
    .s_cfg_mgmt_write           (s_wr),
    .s_cfg_mgmt_write_data      (s_wd),
    .s_cfg_mgmt_byte_enable     (s_be),
    .s_cfg_mgmt_read            (s_rd),
    .s_cfg_mgmt_read_data       (s_rdata),
    .s_cfg_mgmt_read_write_done (s_done),
    .s_cfg_mgmt_error           (s_err),
    .m_cfg_mgmt_addr            (m_addr),
    .m_cfg_mgmt_function_number (m_fn),
    .m_cfg_mgmt_write           (m_write),
    .m_cfg_mgmt_write_data      (m_wd),
    .m_cfg_mgmt_byte_enable     (m_be),
    .m_cfg_mgmt_read            (m_read),
    .m_cfg_mgmt_read_data       (m_rdata),
    .m_cfg_mgmt_read_write_done (m_done),
    .busy                       (busy)
  );

  typedef struct {
    int             cyc;
    int             ch;
    logic           wr;
    logic           rd;
    logic [AW-1:0]  addr;
    logic [FW-1:0]  fn;
    logic [DW-1:0]  wd;
    logic [BW-1:0]  be;
  } req_t;

  typedef struct {
    int            cyc;
    int            ch;
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  req_t exp_q[$];
  rsp_t rsp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- core model ----------------
  logic          core_busy  = 1'b0;
  int            core_cnt   = 0;
  bit            core_mute  = 1'b0;
  bit            core_fixed = 1'b0;
  int            core_lat   = 0;
  logic [DW-1:0] core_data  = '0;

  initial begin
    int k;
    forever begin
      @(posedge clk);
      #1;
      m_done = 1'b0;
      if (!rst_n) begin
        core_busy = 1'b0;
        continue;
      end
      if (core_busy && !(m_read || m_write)) core_busy = 1'b0;
      if (core_busy) begin
        if (!core_mute) begin
          if (core_cnt == 0) begin
            m_done    = 1'b1;
            m_rdata   = core_fixed ? core_data : DW'($urandom);
            core_busy = 1'b0;
          end else begin
            core_cnt--;
          end
        end
      end else if (m_read || m_write) begin
        core_busy = 1'b1;
        k = $urandom_range(0, 11);
        if (core_fixed)  core_cnt = core_lat;
        else if (k == 0) core_cnt = 20;
        else if (k == 1) core_cnt = 14;
        else             core_cnt = $urandom_range(0, 4);
      end else if (!core_mute && $urandom_range(0, 7) == 0) begin
        m_done  = 1'b1;
        m_rdata = DW'($urandom);
      end
    end
  end

  // ---------------- reference model + monitor ----------------
  initial begin
    int            cyc, phase, ptr, gch, acc_n, g;
    int            waitc[CH];
    logic          prev_act, act, stab_bad;
    logic [CH-1:0] reqs;
    req_t          e, cur;
    rsp_t          r;
    cyc = 0; phase = 0; ptr = 0; gch = 0; acc_n = 0; prev_act = 1'b0; stab_bad = 1'b0;
    foreach (waitc[i]) waitc[i] = 0;
    cur = '{0, 0, 1'b0, 1'b0, '0, '0, '0, '0};
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        phase = 0; ptr = 0; prev_act = 1'b0;
        exp_q.delete();
        rsp_q.delete();
        foreach (waitc[i]) waitc[i] = 0;
        continue;
      end
      chk("busy", busy, phase != 0);
      chk("error_without_done", s_err & ~s_done, '0);
      act = m_read || m_write;
      if (act && !prev_act) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", {m_write, m_read, m_addr}, '0);
        end else begin
          e = exp_q.pop_front();
          chk("grant_cycle", cyc, e.cyc);
          chk("m_fields", {m_write, m_read, m_addr, m_fn, m_wd, m_be},
              {e.wr, e.rd & ~e.wr, e.addr, e.fn, e.wd, e.be});
          cur = e;
          stab_bad = 1'b0;
        end
      end else if (act) begin
        if ({m_write, m_addr, m_fn, m_wd, m_be} !== {cur.wr, cur.addr, cur.fn, cur.wd, cur.be})
          stab_bad = 1'b1;
      end
      prev_act = act;
      if (s_done != '0) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_done", s_done, '0);
        end else begin
          r = rsp_q.pop_front();
          chk("done_cycle", cyc, r.cyc);
          chk("done_vec", s_done, CH'(1) << r.ch);
          chk("read_data", s_rdata, r.data);
          chk("error_vec", s_err, r.err ? (CH'(1) << r.ch) : CH'(0));
          chk("m_stable", stab_bad, 1'b0);
        end
      end
      case (phase)
        0: begin
          reqs = s_rd | s_wr;
          if (reqs != '0) begin
            g = -1;
            for (int k = 0; k < CH; k++)
              if (g < 0 && reqs[(ptr + k) % CH]) g = (ptr + k) % CH;
            e.cyc = cyc + 1; e.ch = g;
            e.wr = s_wr[g]; e.rd = s_rd[g];
            e.addr = s_addr[g*AW +: AW]; e.fn = s_fn[g*FW +: FW];
            e.wd = s_wd[g*DW +: DW]; e.be = s_be[g*BW +: BW];
            exp_q.push_back(e);
            chk("wait_bound", waitc[g] > CH - 1, 1'b0);
            for (int k = 0; k < CH; k++) if (k != g && reqs[k]) waitc[k]++;
            waitc[g] = 0;
            gch = g; acc_n = 0; phase = 1;
          end
        end
        1: begin
          acc_n++;
          if (m_done) begin
            rsp_q.push_back('{cyc + 1, gch, m_rdata, 1'b0});
            phase = 2;
          end
`ifdef CFG_MGMT_ARB_TIMEOUT_EN
          else if (acc_n == TO) begin
            rsp_q.push_back('{cyc + 1, gch, {DW{1'b1}}, 1'b1});
            phase = 2;
          end
`endif
        end
        default: begin
          ptr = (gch + 1) % CH;
          phase = 0;
        end
      endcase
    end
  end

  // ---------------- requesters ----------------
  logic [CH-1:0] active = '0;
  logic [CH-1:0] drop   = '0;

  task automatic start_txn(input int ch, input logic rd, input logic wr, input logic [AW-1:0] addr,
                           input logic [FW-1:0] fn, input logic [DW-1:0] wd, input logic [BW-1:0] be);
    s_rd[ch] = rd; s_wr[ch] = wr;
    s_addr[ch*AW +: AW] = addr; s_fn[ch*FW +: FW] = fn;
    s_wd[ch*DW +: DW] = wd; s_be[ch*BW +: BW] = be;
    active[ch] = 1'b1; drop[ch] = 1'b0;
  endtask

  task automatic step(input logic [CH-1:0] allow, input int prob);
    int k;
    @(posedge clk);
    #1;
    for (int i = 0; i < CH; i++) begin
      if (active[i]) begin
        if (drop[i]) begin
          s_rd[i] = 1'b0; s_wr[i] = 1'b0; active[i] = 1'b0; drop[i] = 1'b0;
        end else if (s_done[i]) begin
          drop[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < CH; i++) begin
      if (!active[i] && allow[i] && $urandom_range(0, 99) < prob) begin
        k = $urandom_range(0, 3);
        start_txn(i, k != 1, k == 1 || k == 2, AW'($urandom), FW'($urandom),
                  DW'($urandom), BW'($urandom));
      end
    end
  endtask

  task automatic drain(input int n);
    bit ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      step('0, 0);
      if (active == '0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drain: active=%b busy=%b, required all idle", active, busy);
    end
  endtask

  task automatic wait_m(input int n);
    bit ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      step('0, 0);
      if (m_read || m_write) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_m: no m_read/m_write within %0d cycles", n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before test end");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("reset_outputs", {s_rdata, s_done, s_err, m_addr, m_fn, m_write, m_wd, m_be, m_read, busy}, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single read, fixed 5-cycle core latency
    core_fixed = 1'b1; core_lat = 4; core_data = 32'h12345678;
    start_txn(0, 1'b1, 1'b0, 10'h004, 8'h00, 32'h0, 4'hF);
    drain(100);
    chk("single_read_data", s_rdata, 32'h12345678);
    core_fixed = 1'b0;

    // Write on channel 1
    start_txn(1, 1'b0, 1'b1, 10'h010, 8'h01, 32'hA5A5A5A5, 4'h3);
    wait_m(20);
    chk("write_fields", {m_write, m_read, m_addr, m_wd, m_be}, {1'b1, 1'b0, 10'h010, 32'hA5A5A5A5, 4'h3});
    drain(100);

    // Read and write together resolve to a write
    start_txn(0, 1'b1, 1'b1, 10'h020, 8'h02, 32'h0BADF00D, 4'hF);
    wait_m(20);
    chk("rw_both", {m_write, m_read}, 2'b10);
    drain(100);

    // All channels requesting continuously, then random traffic
    repeat (60) step('1, 100);
    drain(300);
    repeat (3000) step('1, 30);
    drain(500);

`ifdef CFG_MGMT_ARB_TIMEOUT_EN
    core_mute = 1'b1;
    start_txn(0, 1'b1, 1'b0, 10'h030, 8'h00, 32'h0, 4'hF);
    start_txn(2, 1'b0, 1'b1, 10'h040, 8'h00, 32'h1, 4'h1);
    for (int i = 0; i < 40; i++) begin
      step('0, 0);
      if (s_done != '0) break;
    end
    chk("timeout_done_err", {s_done, s_err}, {CH'(1), CH'(1)});
    chk("timeout_rdata", s_rdata, 32'hFFFFFFFF);
    drain(100);
    core_mute = 1'b0;
`endif

    // Leave the pointer at 2, then reset in the middle of a ch1 access
    start_txn(1, 1'b1, 1'b0, 10'h111, 8'h11, 32'h0, 4'hF);
    drain(100);
    core_mute = 1'b1;
    start_txn(1, 1'b1, 1'b0, 10'h111, 8'h11, 32'h0, 4'hF);
    wait_m(20);
    step('0, 0);
    #1 rst_n = 1'b0;
    #1 chk("midreset_outputs", {s_rdata, s_done, s_err, m_addr, m_fn, m_write, m_wd, m_be, m_read, busy}, '0);
    start_txn(2, 1'b1, 1'b0, 10'h222, 8'h22, 32'h0, 4'hF);
    step('0, 0);
    step('0, 0);
    rst_n = 1'b1;
    core_mute = 1'b0;
    wait_m(20);
    chk("regrant_addr", m_addr, 10'h111);
    drain(200);
    repeat (4) step('0, 0);
    chk("queues_empty", exp_q.size() + rsp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
